// File: rtl/seg7_scan_capture_if.sv
// Scan-pin and result bundle for seg7_scan_capture.
//   anodes      : digit enables, active-low (driven by the display side)
//   segments    : segment lines {g,f,e,d,c,b,a}, active-low
//   value       : last published frame, digit i in bits [4i+3:4i]
//   value_valid : one-cycle publish pulse
//   digit_err   : per-digit illegal-glyph flags of the published frame
//   anode_err   : one-cycle pulse on a settled sample with several anodes low
//   stale       : set on frame timeout, cleared by the next publish
// Modports: master = scan source / observer, slave = capture block.
interface seg7_scan_capture_if;
    logic [3:0]  anodes;
    logic [6:0]  segments;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  digit_err;
    logic        anode_err;
    logic        stale;

    modport master (
        output anodes, segments,
        input  value, value_valid, digit_err, anode_err, stale
    );

    modport slave (
        input  anodes, segments,
        output value, value_valid, digit_err, anode_err, stale
    );
endinterface

// File: rtl/seg7_scan_capture.sv
// Loop-back capture of a four-digit multiplexed seven-segment scan.
// Synchronizes the active-low anode/segment pins, waits for each digit to
// settle, decodes the glyph back to a hex nibble and publishes a 16-bit value
// once all four digits of a frame have been seen.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : seg7_scan_capture_if.slave (pins in, results out)
// Parameters:
//   SETTLE  : identical synchronized samples required before a capture (>=2)
//   TIMEOUT : cycles without a capture before a partial frame is dropped
// Optional feature macro: SEG7_CAP_CHANGE_ONLY_EN -- value_valid pulses only
// when the published {value,digit_err} changes (or on the first publish).
module seg7_scan_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    seg7_scan_capture_if.slave bus
);
    localparam int unsigned PIN_W    = 11;
    localparam int unsigned STABLE_W = $clog2(SETTLE + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
    // The counter starts after the first matching compare, so the capture
    // fires once it has seen SETTLE-2 further matches.
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(SETTLE - 2);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    // Glyph to {illegal, nibble}; illegal glyphs decode to nibble 0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] glyph);
        logic [4:0] r;
        case (glyph)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    logic [PIN_W-1:0]    sync1;
    logic [PIN_W-1:0]    sync2;
    logic [PIN_W-1:0]    prev;
    logic [STABLE_W-1:0] stable_cnt;
    logic                armed;
    state_t              state;
    logic [3:0]          seen;
    logic [3:0][3:0]     shadow_val;
    logic [3:0]          shadow_err;
    logic [TO_W-1:0]     to_cnt;
`ifdef SEG7_CAP_CHANGE_ONLY_EN
    logic                published;
`endif

    logic       match_c;
    logic       settled_c;
    logic       blank_c;
    logic       one_low_c;
    logic       multi_low_c;
    logic       take_c;
    logic       consume_c;
    logic [3:0] sel_c;
    logic [1:0] idx_c;
    logic [4:0] glyph_c;
    logic [3:0] seen_set_c;

    // Stability filter decision and anode classification of the stage-2 sample.
    always_comb begin
        sel_c       = ~sync2[10:7];
        match_c     = (sync2 == prev);
        settled_c   = armed && match_c && (stable_cnt == STABLE_LAST);
        blank_c     = (sel_c == 4'h0);
        one_low_c   = !blank_c && ((sel_c & (sel_c - 4'h1)) == 4'h0);
        multi_low_c = !blank_c && !one_low_c;
        idx_c       = 2'd0;
        case (sel_c)
            4'b0010: idx_c = 2'd1;
            4'b0100: idx_c = 2'd2;
            4'b1000: idx_c = 2'd3;
            default: idx_c = 2'd0;
        endcase
        glyph_c    = decode_glyph(sync2[6:0]);
        seen_set_c = seen | (4'b0001 << idx_c);
        take_c     = settled_c && one_low_c && (state == COLLECT);
        // A digit settling during PUBLISH stays armed and is taken next cycle.
        consume_c  = settled_c && !(one_low_c && (state == PUBLISH));
    end

    // Synchronizer, filter, frame FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1           <= '1;
            sync2           <= '1;
            prev            <= '1;
            stable_cnt      <= '0;
            armed           <= 1'b1;
            state           <= COLLECT;
            seen            <= '0;
            shadow_val      <= '0;
            shadow_err      <= '0;
            to_cnt          <= '0;
            bus.value       <= '0;
            bus.value_valid <= 1'b0;
            bus.digit_err   <= '0;
            bus.anode_err   <= 1'b0;
            bus.stale       <= 1'b0;
`ifdef SEG7_CAP_CHANGE_ONLY_EN
            published       <= 1'b0;
`endif
        end else begin
            sync1 <= {bus.anodes, bus.segments};
            sync2 <= sync1;
            prev  <= sync2;

            if (!match_c) begin
                stable_cnt <= '0;
                armed      <= 1'b1;
            end else begin
                if (stable_cnt != STABLE_LAST) begin
                    stable_cnt <= stable_cnt + STABLE_W'(1);
                end
                if (consume_c) begin
                    armed <= 1'b0;
                end
            end

            bus.anode_err   <= settled_c && multi_low_c;
            bus.value_valid <= 1'b0;

            if (state == COLLECT) begin
                if (take_c) begin
                    shadow_val[idx_c] <= glyph_c[3:0];
                    shadow_err[idx_c] <= glyph_c[4];
                    seen              <= seen_set_c;
                    to_cnt            <= '0;
                    if (seen_set_c == 4'hF) begin
                        state <= PUBLISH;
                    end
                end else if (to_cnt == TO_LAST) begin
                    seen       <= '0;
                    shadow_val <= '0;
                    shadow_err <= '0;
                    bus.stale  <= 1'b1;
                    to_cnt     <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end else begin
                bus.value     <= shadow_val;
                bus.digit_err <= shadow_err;
                bus.stale     <= 1'b0;
`ifdef SEG7_CAP_CHANGE_ONLY_EN
                bus.value_valid <= !published ||
                                   (shadow_val != bus.value) ||
                                   (shadow_err != bus.digit_err);
                published       <= 1'b1;
`else
                bus.value_valid <= 1'b1;
`endif
                seen       <= '0;
                shadow_val <= '0;
                shadow_err <= '0;
                state      <= COLLECT;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: scan frames are driven on the
// pins, the expected publish is queued from a glyph-table model, and every
// value_valid pops and compares one entry.
module tb_seg7_scan_capture;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 1024;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  err;
    } frame_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    seg7_scan_capture_if bus();

    seg7_scan_capture #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     valid_cnt = 0;
    int     aerr_cnt = 0;
    int     last_valid_cyc = -1;
    int     t0 = 0;
    logic   prev_vv = 1'b0;
    frame_t sb[$];
    frame_t model_last = '0;
    logic   model_pub_once = 1'b0;

    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer and pulse counters.
    always @(negedge clk) begin
        frame_t f;
        if (reset) begin
            if (bus.value_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                check_eq("vv_single_cycle", 32'(prev_vv), 0);
                check_eq("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    f = sb.pop_front();
                    check_eq("value", 32'(bus.value), 32'(f.value));
                    check_eq("digit_err", 32'(bus.digit_err), 32'(f.err));
                end
            end
            if (bus.anode_err) aerr_cnt++;
        end
        prev_vv = bus.value_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Expected publish for glyphs g[3..0]; queued only if a pulse is expected.
    task automatic model_frame(input logic [3:0][6:0] g);
        frame_t f;
        logic   hit;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            hit = 1'b0;
            for (int n = 0; n < 16; n++) begin
                if (glyph_tab[n] == g[i]) begin
                    f.value[4*i +: 4] = 4'(n);
                    hit = 1'b1;
                end
            end
            if (!hit) f.err[i] = 1'b1;
        end
`ifdef SEG7_CAP_CHANGE_ONLY_EN
        if (!model_pub_once || f != model_last) sb.push_back(f);
`else
        sb.push_back(f);
`endif
        model_last     = f;
        model_pub_once = 1'b1;
    endtask

    task automatic drive_for(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.anodes   = a;
        bus.segments = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_digit(input int idx, input logic [6:0] g, input int hold);
        logic [3:0] sel;
        sel = 4'b0001 << idx;
        if (idx == 0) t0 = cyc;
        drive_for(~sel, g, hold);
        drive_for(4'hF, 7'h7F, 2);
    endtask

    task automatic send_frame(input logic [3:0][6:0] g);
        model_frame(g);
        for (int i = 3; i >= 0; i--) send_digit(i, g[i], 10);
    endtask

    initial begin
        int v0;
        int a0;
        bus.anodes   = 4'hF;
        bus.segments = 7'h7F;
        repeat (3) @(negedge clk);
        check_eq("rst_value", 32'(bus.value), 0);
        check_eq("rst_valid", 32'(bus.value_valid), 0);
        check_eq("rst_digit_err", 32'(bus.digit_err), 0);
        check_eq("rst_anode_err", 32'(bus.anode_err), 0);
        check_eq("rst_stale", 32'(bus.stale), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frame 1,2,3,4 and fixed publish latency.
        send_frame({7'h79, 7'h24, 7'h30, 7'h19});
        check_eq("latency", 32'(last_valid_cyc - t0), 32'(SETTLE + 3));

        // Illegal glyph on digit 2.
        send_frame({7'h08, 7'h7F, 7'h03, 7'h0E});

        // Short glitch in the middle of digit 2 is not captured.
        v0 = valid_cnt;
        model_frame({7'h46, 7'h21, 7'h06, 7'h0E});
        send_digit(3, 7'h46, 10);
        drive_for(4'b1011, 7'h21, 6);
        drive_for(4'b1011, 7'h00, 3);
        drive_for(4'b1011, 7'h21, 6);
        drive_for(4'hF, 7'h7F, 2);
        send_digit(1, 7'h06, 10);
        send_digit(0, 7'h0E, 10);
        check_eq("glitch_one_publish", 32'(valid_cnt - v0), 1);

        // Two anodes low: one error pulse, frame collection unaffected.
        model_frame({7'h40, 7'h79, 7'h24, 7'h30});
        send_digit(3, 7'h40, 10);
        send_digit(2, 7'h79, 10);
        a0 = aerr_cnt;
        drive_for(4'b1100, 7'h40, 10);
        drive_for(4'hF, 7'h7F, 2);
        check_eq("anode_err_pulses", 32'(aerr_cnt - a0), 1);
        send_digit(1, 7'h24, 10);
        send_digit(0, 7'h30, 10);

        // Partial frame followed by a long blank times out.
        v0 = valid_cnt;
        send_digit(0, 7'h79, 10);
        send_digit(1, 7'h24, 10);
        drive_for(4'hF, 7'h7F, TIMEOUT + 10);
        check_eq("stale_set", 32'(bus.stale), 1);
        check_eq("timeout_no_publish", 32'(valid_cnt - v0), 0);
        send_frame({7'h10, 7'h00, 7'h78, 7'h02});
        check_eq("stale_cleared", 32'(bus.stale), 0);

        // Reset in the middle of a frame.
        send_digit(3, 7'h79, 10);
        send_digit(2, 7'h24, 10);
        send_digit(1, 7'h30, 10);
        reset = 1'b0;
        model_pub_once = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_value", 32'(bus.value), 0);
        check_eq("mid_rst_digit_err", 32'(bus.digit_err), 0);
        check_eq("mid_rst_stale", 32'(bus.stale), 0);
        check_eq("mid_rst_valid", 32'(bus.value_valid), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        v0 = valid_cnt;
        send_frame({7'h12, 7'h12, 7'h12, 7'h12});
        check_eq("post_rst_one_publish", 32'(valid_cnt - v0), 1);

        // Repeating the same frame.
        v0 = valid_cnt;
        send_frame({7'h12, 7'h12, 7'h12, 7'h12});
`ifdef SEG7_CAP_CHANGE_ONLY_EN
        check_eq("repeat_publish_count", 32'(valid_cnt - v0), 0);
`else
        check_eq("repeat_publish_count", 32'(valid_cnt - v0), 1);
`endif
        check_eq("repeat_value", 32'(bus.value), 32'h5555);

        repeat (4) @(negedge clk);
        check_eq("sb_drain", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
